// File: rtl/systolic_pkg.sv
// Shared definitions for the 1xN systolic MAC row: FSM states and default
// geometry constants used by the top level and the processing elements.
package systolic_pkg;

   localparam int DEF_N  = 4;
   localparam int DEF_DW = 16;
   localparam int DEF_AW = 40;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate processing element: full-width product extended
// to the accumulator width, accumulation wraps modulo 2^AW.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int AW     = DEF_AW,
   parameter int SIGNED = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [AW-1:0] acc
);

   logic [AW-1:0] prod_ext;

   // Operands are widened before multiplying so the product keeps all 2*DW bits.
   generate
      if (SIGNED != 0) begin : g_signed
         logic signed [2*DW-1:0] sprod;
         assign sprod    = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
         assign prod_ext = AW'(sprod);
      end else begin : g_unsigned
         logic [2*DW-1:0] uprod;
         assign uprod    = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
         assign prod_ext = AW'(uprod);
      end
   endgenerate

   // A clear from a new job wins over any beat arriving in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/systolic_1xn.sv
// 1xN systolic MAC row: a shared b operand and the valid bit ripple down a
// skew chain so PE i sees a beat i cycles after PE0; a small FSM runs jobs.
module systolic_1xn
   import systolic_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int DW     = DEF_DW,
   parameter int AW     = DEF_AW,
   parameter int SIGNED = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [15:0]     k_len,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] a_flat,
   input  logic [DW-1:0]   b,
   output logic [N*AW-1:0] c_flat,
   output logic            out_valid,
   output logic            busy
);

   state_e        state;
   logic [15:0]   beat_cnt;
   logic [15:0]   k_reg;
   logic [3:0]    drain_cnt;
   logic          start_acc;
   logic          accept;

   logic [DW-1:0] b_sk [1:N-1];
   logic          v_sk [1:N-1];

   assign start_acc = start && (state == ST_IDLE || state == ST_DONE);
   assign accept    = in_valid && (state == ST_RUN);
   assign in_ready  = (state == ST_RUN);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state == ST_RUN) || (state == ST_DRAIN);

   // Drain waits N-1 cycles after the last beat so the far PE has consumed it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         beat_cnt  <= '0;
         k_reg     <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_acc) begin
                  k_reg    <= k_len;
                  beat_cnt <= '0;
                  state    <= (k_len == 16'd0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (beat_cnt == k_reg - 16'd1) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= 4'(N - 1);
                  end else begin
                     beat_cnt <= beat_cnt + 16'd1;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == 4'd1) begin
                  state <= ST_DONE;
               end else begin
                  drain_cnt <= drain_cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Skew chain shifts every cycle; a new job flushes any beat still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 1; j < N; j++) begin
            b_sk[j] <= '0;
            v_sk[j] <= 1'b0;
         end
      end else begin
         b_sk[1] <= b;
         v_sk[1] <= accept;
         for (int j = 2; j < N; j++) begin
            b_sk[j] <= b_sk[j-1];
            v_sk[j] <= v_sk[j-1] && !start_acc;
         end
      end
   end

   generate
      for (genvar i = 0; i < N; i++) begin : g_pe
         logic [DW-1:0] a_i;
         logic [DW-1:0] b_i;
         logic          v_i;
         logic [AW-1:0] acc_i;

         if (i == 0) begin : g_head
            assign a_i = a_flat[DW-1:0];
            assign b_i = b;
            assign v_i = accept;
         end else begin : g_tail
            logic [DW-1:0] a_dly [1:i];

            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  for (int j = 1; j <= i; j++) begin
                     a_dly[j] <= '0;
                  end
               end else begin
                  a_dly[1] <= a_flat[i*DW +: DW];
                  for (int j = 2; j <= i; j++) begin
                     a_dly[j] <= a_dly[j-1];
                  end
               end
            end

            assign a_i = a_dly[i];
            assign b_i = b_sk[i];
            assign v_i = v_sk[i];
         end

         systolic_pe #(
            .DW     (DW),
            .AW     (AW),
            .SIGNED (SIGNED)
         ) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clear (start_acc),
            .en    (v_i),
            .a     (a_i),
            .b     (b_i),
            .acc   (acc_i)
         );

         assign c_flat[i*AW +: AW] = acc_i;
      end
   endgenerate

endmodule

// File: tb/tb_systolic_1xn.sv
// Self-checking bench: three configurations of the row share one stimulus
// stream and are compared every cycle against a job-level arithmetic model.
module tb_systolic_1xn;

   localparam int N = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [15:0]  k_len;
   logic         in_valid;
   logic [63:0]  a_flat;
   logic [15:0]  b;

   logic [2:0]   rdy;
   logic [2:0]   ov;
   logic [2:0]   bz;
   logic [159:0] c0;
   logic [127:0] c1;
   logic [159:0] c2;

   int passed = 0;
   int total  = 0;
   bit chkEn  = 0;

   // Model: job phase (0 idle, 1 taking beats, 2 draining, 3 done) plus
   // the full-precision dot-product sums each lane must end up with.
   int          mphase = 0;
   int          left = 0;
   longint      cyc = 0;
   longint      doneCyc = 0;
   logic [63:0] msum [3][N];
   int          awv [3] = '{40, 32, 40};

   systolic_1xn #(.N(N), .DW(16), .AW(40), .SIGNED(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
      .in_ready(rdy[0]), .a_flat(a_flat), .b(b), .c_flat(c0),
      .out_valid(ov[0]), .busy(bz[0]));

   systolic_1xn #(.N(N), .DW(16), .AW(32), .SIGNED(0)) dut1 (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
      .in_ready(rdy[1]), .a_flat(a_flat), .b(b), .c_flat(c1),
      .out_valid(ov[1]), .busy(bz[1]));

   systolic_1xn #(.N(N), .DW(16), .AW(40), .SIGNED(1)) dut2 (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
      .in_ready(rdy[2]), .a_flat(a_flat), .b(b), .c_flat(c2),
      .out_valid(ov[2]), .busy(bz[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [159:0] got, input logic [159:0] exp);
      total++;
      if (got === exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit st, input logic [15:0] k, input bit v,
                                input logic [63:0] a, input logic [15:0] bb);
      start    = st;
      k_len    = k;
      in_valid = v;
      a_flat   = a;
      b        = bb;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 16'd0, 1'b0, 64'd0, 16'd0);
   endtask

   // Runs cycles until the model reaches done; beats are random when asked.
   task automatic waitDone(input bit randomBeats);
      int n = 0;
      while (mphase != 3 && n < 200) begin
         if (randomBeats) begin
            applyStimulus($urandom_range(0, 9) == 0, 16'($urandom_range(0, 3)),
                          $urandom_range(0, 3) != 0, {$urandom, $urandom}, 16'($urandom));
         end else begin
            idleCycle();
         end
         n++;
      end
      checkOutput("job_completes_within_budget", 160'(mphase), 160'd3);
   endtask

   function automatic logic [159:0] expC(int d);
      logic [159:0] r;
      logic [63:0]  mask;
      r    = '0;
      mask = (64'd1 << awv[d]) - 64'd1;
      for (int i = 0; i < N; i++) begin
         r |= 160'(msum[d][i] & mask) << (i * awv[d]);
      end
      return r;
   endfunction

   function automatic logic [159:0] gotC(int d);
      if (d == 0) return c0;
      if (d == 1) return {32'd0, c1};
      return c2;
   endfunction

   // Model advances on each rising edge using the inputs the DUT also sees.
   always @(posedge clk) begin : model
      longint sx;
      longint sy;
      logic [15:0] ai;
      cyc++;
      if (rst) begin
         mphase = 0;
         for (int d = 0; d < 3; d++) for (int i = 0; i < N; i++) msum[d][i] = '0;
      end else if (start && (mphase == 0 || mphase == 3)) begin
         for (int d = 0; d < 3; d++) for (int i = 0; i < N; i++) msum[d][i] = '0;
         if (k_len == 16'd0) begin
            mphase = 3;
         end else begin
            mphase = 1;
            left   = k_len;
         end
      end else if (mphase == 1 && in_valid) begin
         for (int i = 0; i < N; i++) begin
            ai = a_flat[i*16 +: 16];
            msum[0][i] += 64'(ai) * 64'(b);
            msum[1][i] += 64'(ai) * 64'(b);
            sx = $signed(ai);
            sy = $signed(b);
            msum[2][i] += 64'(sx * sy);
         end
         left--;
         if (left == 0) begin
            mphase  = 2;
            doneCyc = cyc + N - 1;
         end
      end else if (mphase == 2 && cyc == doneCyc) begin
         mphase = 3;
      end
   end

   // Compare every DUT against the model on each falling edge.
   always @(negedge clk) begin
      if (chkEn && !rst) begin
         for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("in_ready[%0d]", d), 160'(rdy[d]), 160'(mphase == 1));
            checkOutput($sformatf("busy[%0d]", d), 160'(bz[d]), 160'(mphase == 1 || mphase == 2));
            checkOutput($sformatf("out_valid[%0d]", d), 160'(ov[d]), 160'(mphase == 3));
            if (mphase == 3) begin
               checkOutput($sformatf("c_flat[%0d]", d), gotC(d), expC(d));
            end
         end
      end
   end

   initial begin
      int cnt;
      rst = 1'b0;
      start = 1'b0; k_len = '0; in_valid = 1'b0; a_flat = '0; b = '0;
      #2 rst = 1'b1;
      #1;
      checkOutput("reset_outputs", {ov, bz, rdy}, 160'd0);
      checkOutput("reset_c0", c0, 160'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chkEn = 1'b1;

      // Single beat, a=(1,2,3,4), b=5: done three edges after acceptance.
      applyStimulus(1'b1, 16'd1, 1'b0, 64'd0, 16'd0);
      applyStimulus(1'b0, 16'd0, 1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 16'd5);
      cnt = 0;
      while (!ov[0] && cnt < 20) begin
         idleCycle();
         cnt++;
      end
      checkOutput("latency_single_beat", 160'(cnt), 160'd3);
      checkOutput("lit_c_1_2_3_4_x5", c0, {40'd20, 40'd15, 40'd10, 40'd5});

      // Three beats of a=2 with b=1,2,3 and a bubble after the first.
      applyStimulus(1'b1, 16'd3, 1'b0, 64'd0, 16'd0);
      applyStimulus(1'b0, 16'd0, 1'b1, {4{16'd2}}, 16'd1);
      applyStimulus(1'b0, 16'd0, 1'b0, {4{16'd2}}, 16'd9);
      checkOutput("lit_busy_in_bubble", 160'(bz[0]), 160'd1);
      applyStimulus(1'b0, 16'd0, 1'b1, {4{16'd2}}, 16'd2);
      applyStimulus(1'b0, 16'd0, 1'b1, {4{16'd2}}, 16'd3);
      waitDone(1'b0);
      checkOutput("lit_c_12_each", c0, {4{40'd12}});

      // -3 * 7 in signed and unsigned interpretation.
      applyStimulus(1'b1, 16'd1, 1'b0, 64'd0, 16'd0);
      applyStimulus(1'b0, 16'd0, 1'b1, {48'd0, 16'hFFFD}, 16'd7);
      waitDone(1'b0);
      checkOutput("lit_signed_neg21", 160'(c2[39:0]), 160'h00_FFFF_FFFF_EB);
      checkOutput("lit_unsigned_fffd_x7", 160'(c0[39:0]), 160'h6_FFEB);

      // Four beats of 0xFFFF*0xFFFF: wraps in the 32-bit accumulator.
      applyStimulus(1'b1, 16'd4, 1'b0, 64'd0, 16'd0);
      repeat (4) applyStimulus(1'b0, 16'd0, 1'b1, {4{16'hFFFF}}, 16'hFFFF);
      waitDone(1'b0);
      checkOutput("lit_wrap_aw32", 160'(c1[31:0]), 160'hFFF8_0004);
      checkOutput("lit_nowrap_aw40", 160'(c0[159:120]), 160'h3_FFF8_0004);
      checkOutput("lit_signed_minus1_sq", 160'(c2[39:0]), 160'd4);

      // start held high through a job is ignored; start in done restarts.
      applyStimulus(1'b1, 16'd2, 1'b0, 64'd0, 16'd0);
      applyStimulus(1'b1, 16'd0, 1'b1, {4{16'd3}}, 16'd3);
      applyStimulus(1'b1, 16'd0, 1'b1, {4{16'd1}}, 16'd1);
      applyStimulus(1'b1, 16'd0, 1'b0, 64'd0, 16'd0);
      checkOutput("lit_start_ignored_drain", 160'(bz[0]), 160'd1);
      waitDone(1'b0);
      checkOutput("lit_c_10_each", c0, {4{40'd10}});
      applyStimulus(1'b1, 16'd5, 1'b0, 64'd0, 16'd0);
      checkOutput("lit_restart_clears", c0, 160'd0);
      checkOutput("lit_restart_ready", 160'(rdy[0]), 160'd1);
      waitDone(1'b1);

      // Reset during drain, then a zero-length job.
      applyStimulus(1'b1, 16'd1, 1'b0, 64'd0, 16'd0);
      applyStimulus(1'b0, 16'd0, 1'b1, {4{16'd9}}, 16'd9);
      #2 rst = 1'b1;
      #1;
      checkOutput("lit_rst_drain_flags", {ov, bz, rdy}, 160'd0);
      checkOutput("lit_rst_drain_c", c0, 160'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      applyStimulus(1'b1, 16'd0, 1'b0, 64'd0, 16'd0);
      checkOutput("lit_klen0_done", 160'(ov[0]), 160'd1);
      checkOutput("lit_klen0_c", c0, 160'd0);

      // Random jobs with bubbles, stray starts and idle gaps.
      for (int j = 0; j < 40; j++) begin
         applyStimulus(1'b1, 16'($urandom_range(0, 6)), $urandom_range(0, 1) == 1,
                       {$urandom, $urandom}, 16'($urandom));
         waitDone(1'b1);
         repeat ($urandom_range(0, 2)) begin
            applyStimulus(1'b0, 16'd0, $urandom_range(0, 1) == 1, {$urandom, $urandom}, 16'($urandom));
         end
      end

      chkEn = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/systolic_1xn.md
SYSTOLIC_1XN -- requirements
Module: systolic_1xn

Interface
REQ-001 Parameter N, default 4: number of PEs, legal range 2..16.
REQ-002 Parameter DW, default 16: operand width.
REQ-003 Parameter AW, default 40: accumulator width, at least 2*DW.
REQ-004 Parameter SIGNED, default 0: 1 = two's-complement operands, 0 = unsigned.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle request to clear the accumulators and begin a job.
REQ-008 k_len  in  16  number of MAC beats in the job; sampled when start is accepted.
REQ-009 in_valid  in  1  the a_flat/b beat is valid.
REQ-010 in_ready  out  1  the block accepts a beat this cycle.
REQ-011 a_flat  in  N*DW  per-PE operand; lane i is bits [i*DW +: DW]; all lanes time-aligned by the caller.
REQ-012 b  in  DW  shared operand broadcast along the chain.
REQ-013 c_flat  out  N*AW  accumulator of PE i in lane i.
REQ-014 out_valid  out  1  c_flat holds the final result of the job.
REQ-015 busy  out  1  high in RUN or DRAIN.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-017 start is accepted only in IDLE or DONE; it is ignored in RUN and DRAIN.
REQ-018 Accepted start with k_len>0: clear all accumulators and go to RUN at the same edge.
REQ-019 Accepted start with k_len=0: clear all accumulators and go directly to DONE.
REQ-020 in_ready=1 only in RUN; a beat is accepted when in_valid && in_ready.
REQ-021 Bubbles (in_valid=0 in RUN) are legal, cause no accumulation, and stall nothing.
REQ-022 For a beat accepted at edge E: PE0 adds a0*b at edge E; PE i adds a_i*b at edge E+i.
REQ-023 Skewing: b, a lanes 1..N-1 and the valid bit are delayed internally by i register stages for PE i.
REQ-024 Skew registers advance every cycle regardless of FSM state.
REQ-025 RUN counts accepted beats; acceptance of beat k_len moves to DRAIN, loading drain count N-1.
REQ-026 DRAIN decrements its count each cycle; DONE is entered at edge E_last+N-1.
REQ-027 out_valid=1 exactly in DONE; c_flat holds stable until the next accepted start.
REQ-028 Products are full 2*DW bits; they are sign-extended when SIGNED=1, zero-extended otherwise, to AW bits.
REQ-029 Accumulation wraps modulo 2^AW; no saturation or overflow flag.
REQ-030 When start is accepted in DONE, a queued beat still in the skew chain is discarded, not accumulated.
REQ-031 c_flat is combinationally driven from the accumulator registers.

Reset
REQ-032 On rst, asynchronously: FSM=IDLE, all accumulators, skew registers, valid bits and counters become 0.
REQ-033 Reset values of outputs: in_ready=0, out_valid=0, busy=0, c_flat=0.
REQ-034 Reset mid-job (RUN/DRAIN) abandons the job with no partial result flagged.

Structure
REQ-035 Package systolic_pkg holds the FSM state enum and default parameter constants (N, DW, AW).
REQ-036 Sub-module systolic_pe (DW, AW, SIGNED): inputs clear, en, a, b; output acc.
REQ-037 systolic_pe is instantiated N times by a generate loop; skew chains and the FSM live in the top level.

Verification
REQ-038 N=4, DW=16, unsigned: start with k_len=1, a=(1,2,3,4), b=5 -> out_valid 3 cycles after acceptance; c=(5,10,15,20).
REQ-039 k_len=3, b=(1,2,3), all a lanes=2, one bubble after beat 1 -> c=12 in each lane; busy high until DONE.
REQ-040 SIGNED=1: a0=-3 (0xFFFD), b=7, k_len=1 -> c0=-21 sign-extended to AW; repeat with SIGNED=0 -> c0=0xFFFD*7.
REQ-041 AW=32, DW=16, four beats of 0xFFFF*0xFFFF -> c wraps modulo 2^32 to 0xFFF80004.
REQ-042 rst asserted in DRAIN -> all outputs 0 immediately; a later start with k_len=0 -> DONE next cycle with c=0.
REQ-043 start held in RUN is ignored; start in DONE clears c_flat and returns the FSM to RUN.
